// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: redirect input, instruction-memory req/ack port and IF/ID dequeue port.
// master = the queue itself, slave = the pipeline/memory side driving it.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                           redirectValid;
  logic [31:0]                    redirectPc;
  logic                           imemReq;
  logic [31:0]                    imemAddr;
  logic                           imemAck;
  logic [31:0]                    imemData;
  logic                           deqReady;
  logic                           deqValid;
  logic [31:0]                    deqInst;
  logic [31:0]                    deqPcPlus4;
  logic [$clog2(DEPTH+1)-1:0]     occupancy;

  modport master (
    input  redirectValid, redirectPc, imemAck, imemData, deqReady,
    output imemReq, imemAddr, deqValid, deqInst, deqPcPlus4, occupancy
  );

  modport slave (
    output redirectValid, redirectPc, imemAck, imemData, deqReady,
    input  imemReq, imemAddr, deqValid, deqInst, deqPcPlus4, occupancy
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: one outstanding imem request, ack in cycle N is dequeueable in N+1.
// Stops requesting when full; deqReady low simply holds the head entry; redirects flush and drain stale fetches.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic            clk,
  input logic            rst,
  inst_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [31:0]      fetchPc;
  logic [31:0]      staleAddr;
  logic [31:0]      instMem [DEPTH];
  logic [31:0]      pcMem   [DEPTH];

  logic enq;
  logic deq;

  // imemReq is gated by reset so it drops immediately, not at the next edge.
  always_comb begin
    bus.imemReq    = rst && ((state == DRAIN) || (count != FULL));
    bus.imemAddr   = (state == DRAIN) ? staleAddr : fetchPc;
    bus.deqValid   = (count != '0);
    bus.deqInst    = instMem[rdPtr];
    bus.deqPcPlus4 = pcMem[rdPtr];
    bus.occupancy  = count;
  end

  assign enq = bus.imemReq && bus.imemAck && (state == FETCH) && !bus.redirectValid;
  assign deq = bus.deqValid && bus.deqReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      count     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      fetchPc   <= RESET_PC;
      staleAddr <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        instMem[i] <= '0;
        pcMem[i]   <= '0;
      end
    end else if (bus.redirectValid) begin
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      fetchPc <= {bus.redirectPc[31:2], 2'b00};
      // An un-acked request must stay on the bus until memory answers it.
      if (bus.imemReq && !bus.imemAck) begin
        staleAddr <= bus.imemAddr;
        state     <= DRAIN;
      end else begin
        state <= FETCH;
      end
    end else if (state == DRAIN) begin
      if (bus.imemAck) begin
        state <= FETCH;
      end
    end else begin
      if (enq) begin
        instMem[wrPtr] <= bus.imemData;
        pcMem[wrPtr]   <= fetchPc + 32'd4;
        wrPtr          <= wrPtr + 1'b1;
        fetchPc        <= fetchPc + 32'd4;
      end
      if (deq) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (deq && !enq) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcp4;
  } entry_t;

  // Reference model: FIFO contents, next sequential fetch address, and a
  // pending stale request that must be answered before fetching resumes.
  entry_t      q[$];
  logic [31:0] mPc;
  bit          mDrain;
  logic [31:0] mStale;

  // Memory model: one request at a time, latency drawn per request.
  bit memBusy;
  int memLeft;
  int latMin, latMax, pDeq, pRedir;
  bit forceRedir;
  logic [31:0] forcePc;

  int errCnt = 0;
  int chkCnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit modelReq();
    return mDrain || (q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] modelAddr();
    return mDrain ? mStale : mPc;
  endfunction

  function automatic void modelReset();
    q.delete();
    mPc    = RESET_PC;
    mDrain = 1'b0;
    mStale = RESET_PC;
  endfunction

  function automatic void modelUpdate(input bit req, input logic [31:0] addr, input bit ack,
                                      input logic [31:0] data, input bit rdy, input bit redir,
                                      input logic [31:0] rpc);
    bit doDeq;
    doDeq = (q.size() != 0) && rdy;
    if (redir) begin
      q.delete();
      if (req && !ack) begin
        mDrain = 1'b1;
        mStale = addr;
      end else begin
        mDrain = 1'b0;
      end
      mPc = rpc & 32'hFFFF_FFFC;
    end else if (mDrain) begin
      if (ack) mDrain = 1'b0;
    end else begin
      if (doDeq) void'(q.pop_front());
      if (req && ack) begin
        q.push_back('{inst: data, pcp4: mPc + 32'd4});
        mPc = mPc + 32'd4;
      end
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    chk("imemReq", bus.imemReq, modelReq());
    chk("imemAddr", bus.imemAddr, modelAddr());
    chk("deqValid", bus.deqValid, q.size() != 0);
    chk("occupancy", bus.occupancy, q.size());
    if (q.size() != 0) begin
      chk("deqInst", bus.deqInst, q[0].inst);
      chk("deqPcPlus4", bus.deqPcPlus4, q[0].pcp4);
    end
  endtask

  task automatic drive();
    bit          ack, rdy, redir;
    logic [31:0] data, rpc;
    ack = 1'b0;
    if (bus.imemReq) begin
      if (!memBusy) begin
        memBusy = 1'b1;
        memLeft = $urandom_range(latMax, latMin);
      end
      if (memLeft == 0) begin
        ack     = 1'b1;
        memBusy = 1'b0;
      end else begin
        memLeft--;
      end
    end
    data  = ack ? ~bus.imemAddr : $urandom;
    rdy   = ($urandom_range(0, 99) < pDeq);
    redir = forceRedir || ($urandom_range(0, 99) < pRedir);
    if (forceRedir) rpc = forcePc;
    else if ($urandom_range(0, 9) == 0) rpc = $urandom;
    else rpc = $urandom_range(0, 1023);
    forceRedir = 1'b0;

    bus.imemAck       = ack;
    bus.imemData      = data;
    bus.deqReady      = rdy;
    bus.redirectValid = redir;
    bus.redirectPc    = rpc;
    modelUpdate(modelReq(), modelAddr(), ack, data, rdy, redir, rpc);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      drive();
    end
  endtask

  task automatic quietInputs();
    bus.imemAck       = 1'b0;
    bus.imemData      = '0;
    bus.deqReady      = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectPc    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    quietInputs();
    forceRedir = 1'b0;
    forcePc    = '0;
    memBusy    = 1'b0;
    memLeft    = 0;
    latMin = 0; latMax = 0; pDeq = 100; pRedir = 0;
    modelReset();

    #12;
    chk("rstImemReq", bus.imemReq, 1'b0);
    chk("rstDeqValid", bus.deqValid, 1'b0);
    chk("rstOccupancy", bus.occupancy, 0);
    chk("rstDeqInst", bus.deqInst, 32'h0);
    chk("rstDeqPcPlus4", bus.deqPcPlus4, 32'h0);
    chk("rstImemAddr", bus.imemAddr, RESET_PC);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait memory, always-ready consumer: streaming.
    runCycles(20);

    // Consumer stalled until full, single-cycle release, stall again.
    pDeq = 0;
    runCycles(10);
    pDeq = 100;
    runCycles(1);
    pDeq = 0;
    runCycles(6);

    // Variable latency with random redirects and backpressure.
    latMax = 3; pDeq = 70; pRedir = 10;
    runCycles(600);

    // Zero-wait with frequent redirects that collide with ack and dequeue.
    latMax = 0; pDeq = 80; pRedir = 20;
    runCycles(300);

    // Redirect into DRAIN, then a second redirect while still draining.
    latMin = 3; latMax = 3; pDeq = 100; pRedir = 0;
    guard = 0;
    while (!(memBusy && memLeft >= 2) && guard < 20) begin
      runCycles(1);
      guard++;
    end
    if (!(memBusy && memLeft >= 2)) chk("drainSetupTimeout", bus.imemReq, 1'b0);
    forceRedir = 1'b1; forcePc = 32'h43;
    runCycles(1);
    forceRedir = 1'b1; forcePc = 32'h200;
    runCycles(1);
    sample();
    chk("drainHoldsStale", bus.imemAddr != 32'h200, 1'b1);
    drive();
    runCycles(12);

    // Redirect to the top word: PC+4 wraps to zero.
    latMin = 0; latMax = 0; pDeq = 0; pRedir = 0;
    runCycles(4);
    forceRedir = 1'b1; forcePc = 32'hFFFF_FFFC;
    runCycles(1);
    guard = 0;
    while (q.size() == 0 && guard < 20) begin
      runCycles(1);
      guard++;
    end
    sample();
    chk("wrapDeqValid", bus.deqValid, 1'b1);
    chk("wrapPcPlus4", bus.deqPcPlus4, 32'h0);
    chk("wrapNextAddr", bus.imemAddr, 32'h0);
    drive();
    runCycles(5);

    // Asynchronous reset with two entries queued and a request outstanding.
    latMin = 1; latMax = 3; pDeq = 0; pRedir = 0;
    runCycles(2);
    guard = 0;
    while (!(q.size() == 2 && memBusy) && guard < 60) begin
      if (q.size() > 2) begin
        forceRedir = 1'b1; forcePc = 32'h80;
      end
      runCycles(1);
      guard++;
    end
    if (!(q.size() == 2 && memBusy)) chk("arstSetupTimeout", bus.occupancy, 2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arstImemReq", bus.imemReq, 1'b0);
    chk("arstDeqValid", bus.deqValid, 1'b0);
    chk("arstOccupancy", bus.occupancy, 0);
    chk("arstImemAddr", bus.imemAddr, RESET_PC);
    quietInputs();
    modelReset();
    memBusy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    latMin = 0; latMax = 0; pDeq = 100;
    runCycles(20);

    // Final mixed soak.
    latMax = 2; pDeq = 60; pRedir = 8;
    runCycles(500);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
